div_controller: RTL and testbench
=================================

DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 The block SHALL have parameter ITERS, default 8, giving the number of quotient bits (divide iterations); only 8 is supported by the current datapath.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (reset=0 resets immediately, regardless of clk).
REQ-004 The block SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 The block SHALL have port sign, input, 1 bit: datapath adder MSB (1 = remainder-high minus divisor is negative).
REQ-006 The block SHALL have port load, output, 1 bit: datapath divisor-register load enable.
REQ-007 The block SHALL have port add, output, 1 bit: datapath adder op (1 = add divisor, 0 = subtract divisor).
REQ-008 The block SHALL have port shift, output, 1 bit: datapath shift-left enable for the 16-bit remainder register.
REQ-009 The block SHALL have port inbit, output, 1 bit: bit shifted into remainder[0] when shift=1.
REQ-010 The block SHALL have port sel, output, 2 bits: datapath mux select (01 = adder/low, 10 = {0,dividendin}, 11 = hold).
REQ-011 The block SHALL have port busy, output, 1 bit: high from LOAD through DONE inclusive.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse; quotient and remainder are valid at the datapath outputs.

Function
REQ-013 The block SHALL implement a restoring-division Moore FSM with states IDLE, LOAD, SHIFT0, SUB, TEST and DONE, plus a 3-bit iteration counter cnt and a registered sign_q.
REQ-014 IDLE SHALL drive load=0, add=0, shift=0, inbit=0, sel=11, busy=0 and done=0, and SHALL go to LOAD when start=1, otherwise stay.
REQ-015 LOAD SHALL drive load=1, sel=10 and shift=0 (divisor and {8'h00,dividendin} captured), SHALL clear cnt, and SHALL go to SHIFT0.
REQ-016 SHIFT0 SHALL drive sel=11, shift=1 and inbit=0, and SHALL go to SUB.
REQ-017 SUB SHALL drive sel=01, add=0 and shift=0 (remainder-high := remainder-high minus divisor), SHALL capture sign into sign_q on the same edge, and SHALL go to TEST.
REQ-018 TEST with sign_q=1 SHALL drive sel=01, add=1, shift=1 and inbit=0 (restore and shift in 0).
REQ-019 TEST with sign_q=0 SHALL drive sel=11, shift=1 and inbit=1 (keep and shift in 1).
REQ-020 TEST SHALL increment cnt, SHALL go to DONE when cnt==ITERS-1, and SHALL otherwise go to SUB.
REQ-021 DONE SHALL drive sel=11, shift=0 and done=1 for exactly one cycle, and SHALL then go to IDLE.
REQ-022 Latency: with start sampled at edge E0, LOAD SHALL be active after E0, SUB k after E(2k), TEST k after E(2k+1), and DONE after E18, giving 19 cycles from start to the done pulse.
REQ-023 start SHALL be ignored while busy=1; no queuing and no restart.
REQ-024 start held high across DONE SHALL begin a new divide on the first IDLE cycle, so back-to-back operations have 1 IDLE cycle between them.
REQ-025 Any unused state encoding SHALL return to IDLE on the next edge with IDLE outputs.
REQ-026 Outputs SHALL be decoded from state and sign_q only, with no combinational path from start or sign to any output.
REQ-027 Divisor 0 SHALL not be trapped: the FSM SHALL run to completion, giving quotient 8'hFF and remainder dividendin[6:0].

Reset
REQ-028 On reset=0 the block SHALL asynchronously enter IDLE with cnt=0, sign_q=0, load=0, add=0, shift=0, inbit=0, sel=11, busy=0 and done=0.
REQ-029 Reset asserted mid-operation SHALL abort the divide with no done pulse, and the datapath register contents are don't-care afterwards.
REQ-030 After reset deasserts, the first rising edge SHALL be able to accept start.

Verification
REQ-031 The bench SHALL check: dividendin=100, divisorin=7, pulse start -> done exactly 19 cycles after the start edge, quotient=14, remainder=2.
REQ-032 The bench SHALL check: 255/127 -> quotient=2, remainder=1; and 0/5 -> quotient=0, remainder=0, with the same latency.
REQ-033 The bench SHALL check: 13/0 -> quotient=8'hFF, remainder=13, with done still at 19 cycles.
REQ-034 The bench SHALL check: start re-pulsed at cycles 5 and 18 of an active divide -> ignored, a single done pulse, and the result unchanged.
REQ-035 The bench SHALL check: reset=0 asserted at cycle 9 of a divide -> outputs take their IDLE values immediately with no done; a new 100/7 after release -> quotient 14, remainder 2.
REQ-036 The bench SHALL check: start held high continuously -> done pulses every 20 cycles, and sel/add/shift/inbit match REQ-014..REQ-021 in every cycle.

Source files
------------

// File: rtl/div_controller.sv
// Moore-style control unit for an 8-bit restoring divider.
// It sequences an external 16-bit remainder register and an 8-bit divisor register.
module div_controller #(
    parameter int ITERS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       sign,
    output logic       load,
    output logic       add,
    output logic       shift,
    output logic       inbit,
    output logic [1:0] sel,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT0 = 3'd2,
        S_SUB    = 3'd3,
        S_TEST   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [2:0] LAST_ITER = 3'(ITERS - 1);

    localparam logic [1:0] SEL_ADDER = 2'b01;
    localparam logic [1:0] SEL_INIT  = 2'b10;
    localparam logic [1:0] SEL_HOLD  = 2'b11;

    state_t     state;
    state_t     state_nxt;
    logic [2:0] cnt;
    logic       sign_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 3'd0;
        end else if (state == S_LOAD) begin
            cnt <= 3'd0;
        end else if (state == S_TEST) begin
            cnt <= cnt + 3'd1;
        end
    end

    // The adder sign is sampled while the subtraction is written back, so it
    // reflects remainder-high minus divisor before the subtract.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sign_q <= 1'b0;
        end else if (state == S_SUB) begin
            sign_q <= sign;
        end
    end

    // NOTE: every output and the next state get a default before the case so
    // no path through the block leaves a variable unassigned (no latches).
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        add       = 1'b0;
        shift     = 1'b0;
        inbit     = 1'b0;
        sel       = SEL_HOLD;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                load      = 1'b1;
                sel       = SEL_INIT;
                busy      = 1'b1;
                state_nxt = S_SHIFT0;
            end
            S_SHIFT0: begin
                shift     = 1'b1;
                busy      = 1'b1;
                state_nxt = S_SUB;
            end
            S_SUB: begin
                sel       = SEL_ADDER;
                busy      = 1'b1;
                state_nxt = S_TEST;
            end
            S_TEST: begin
                busy  = 1'b1;
                shift = 1'b1;
                if (sign_q) begin
                    // Negative trial: add the divisor back, quotient bit 0.
                    sel = SEL_ADDER;
                    add = 1'b1;
                end else begin
                    inbit = 1'b1;
                end
                state_nxt = (cnt == LAST_ITER) ? S_DONE : S_SUB;
            end
            S_DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_div_controller.sv
// Bench for div_controller: a behavioural restoring-divide datapath closes the
// loop, and results are scored against plain arithmetic through a queue.
module tb_div_controller;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       sign;
    logic       load;
    logic       add;
    logic       shift;
    logic       inbit;
    logic [1:0] sel;
    logic       busy;
    logic       done;

    logic [7:0]  dividend_in = 8'h00;
    logic [7:0]  divisor_in  = 8'h00;
    logic [15:0] rem         = 16'h0000;
    logic [15:0] rem_nxt;
    logic [7:0]  dvs         = 8'h00;
    logic [8:0]  diff;
    logic [7:0]  quo;
    logic [7:0]  rmd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
    } result_t;

    typedef struct packed {
        logic       load;
        logic       add;
        logic       shift;
        logic       inbit;
        logic [1:0] sel;
        logic       busy;
        logic       done;
    } ctl_t;

    result_t sb[$];
    ctl_t    act;

    always #5 clk = ~clk;

    div_controller #(.ITERS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .sign  (sign),
        .load  (load),
        .add   (add),
        .shift (shift),
        .inbit (inbit),
        .sel   (sel),
        .busy  (busy),
        .done  (done)
    );

    assign act = {load, add, shift, inbit, sel, busy, done};

    // Datapath: mux, 8-bit add/sub on the remainder high half, then optional shift.
    always_comb begin
        rem_nxt = rem;
        case (sel)
            2'b10:   rem_nxt = {8'h00, dividend_in};
            2'b01:   rem_nxt = {(add ? rem[15:8] + dvs : rem[15:8] - dvs), rem[7:0]};
            default: rem_nxt = rem;
        endcase
        if (shift) rem_nxt = {rem_nxt[14:0], inbit};
    end

    always @(posedge clk) begin
        rem <= rem_nxt;
        if (load) dvs <= divisor_in;
    end

    assign diff = {1'b0, rem[15:8]} - {1'b0, dvs};
    assign sign = diff[8];
    assign quo  = rem[7:0];
    assign rmd  = {1'b0, rem[15:9]};

    function automatic result_t ref_div(input logic [7:0] a, input logic [7:0] b);
        result_t res;
        if (b == 8'h00) begin
            res.q = 8'hFF;
            res.r = {1'b0, a[6:0]};
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Expected control word p edges after the start-sampling edge (p<0 or 19 = IDLE).
    function automatic ctl_t exp_ctl(input int p, input logic [7:0] q);
        ctl_t c;
        int   k;
        c     = '0;
        c.sel = 2'b11;
        if (p == 0) begin
            c.load = 1'b1;
            c.sel  = 2'b10;
            c.busy = 1'b1;
        end else if (p == 1) begin
            c.shift = 1'b1;
            c.busy  = 1'b1;
        end else if (p >= 2 && p <= 17) begin
            c.busy = 1'b1;
            if (p % 2 == 0) begin
                c.sel = 2'b01;
            end else begin
                k       = (p - 1) / 2;
                c.shift = 1'b1;
                if (q[8-k]) begin
                    c.inbit = 1'b1;
                end else begin
                    c.sel = 2'b01;
                    c.add = 1'b1;
                end
            end
        end else if (p == 18) begin
            c.busy = 1'b1;
            c.done = 1'b1;
        end
        return c;
    endfunction

    // Launch one divide from a negedge and watch 32 cycles; rp0/rp1 re-pulse start.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int rp0,
                          input int rp1, output int lat, output int pulses,
                          output result_t got);
        lat         = 0;
        pulses      = 0;
        got         = '0;
        dividend_in = a;
        divisor_in  = b;
        sb.push_back(ref_div(a, b));
        start = 1'b1;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            @(negedge clk);
            start = ((cyc - 1) == rp0) || ((cyc - 1) == rp1);
            if (done === 1'b1) begin
                pulses++;
                if (lat == 0) begin
                    lat = cyc;
                    got = {quo, rmd};
                end
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        start = 1'b1;
        #1;
        n_checks++;
        if (act !== exp_ctl(-1, 8'h00)) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected %b", act, exp_ctl(-1, 8'h00));
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (act !== exp_ctl(-1, 8'h00)) begin
            n_fail++;
            $display("FAIL reset_hold: got %b expected %b", act, exp_ctl(-1, 8'h00));
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (act !== exp_ctl(-1, 8'h00)) begin
            n_fail++;
            $display("FAIL idle_after_release: got %b expected %b", act, exp_ctl(-1, 8'h00));
        end
    endtask

    task automatic test_divide;
        logic [7:0] ta[4];
        logic [7:0] tb_b[4];
        int         lat;
        int         pulses;
        result_t    got;
        result_t    exp;
        ta   = '{8'd100, 8'd255, 8'd0, 8'd13};
        tb_b = '{8'd7,   8'd127, 8'd5, 8'd0};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb_b[i], -1, -1, lat, pulses, got);
            exp = sb.pop_front();
            n_checks++;
            if (lat !== 19) begin
                n_fail++;
                $display("FAIL latency %0d/%0d: got %0d expected 19", ta[i], tb_b[i], lat);
            end
            n_checks++;
            if (pulses !== 1) begin
                n_fail++;
                $display("FAIL done_count %0d/%0d: got %0d expected 1", ta[i], tb_b[i], pulses);
            end
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL result %0d/%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                         ta[i], tb_b[i], got.q, got.r, exp.q, exp.r);
            end
        end
    endtask

    task automatic test_ignore_start;
        int      lat;
        int      pulses;
        result_t got;
        result_t exp;
        run_op(8'd100, 8'd7, 5, 18, lat, pulses, got);
        exp = sb.pop_front();
        n_checks++;
        if (pulses !== 1) begin
            n_fail++;
            $display("FAIL ignore_done_count: got %0d expected 1", pulses);
        end
        n_checks++;
        if (lat !== 19) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d expected 19", lat);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL ignore_result: got q=%0d r=%0d expected q=%0d r=%0d",
                     got.q, got.r, exp.q, exp.r);
        end
        n_checks++;
        if ({busy, quo, rmd} !== {1'b0, exp.q, exp.r}) begin
            n_fail++;
            $display("FAIL ignore_after: got busy=%b q=%0d r=%0d expected busy=0 q=%0d r=%0d",
                     busy, quo, rmd, exp.q, exp.r);
        end
    endtask

    task automatic test_reset_mid;
        int      lat;
        int      pulses;
        result_t got;
        result_t exp;
        dividend_in = 8'd100;
        divisor_in  = 8'd7;
        sb.push_back(ref_div(8'd100, 8'd7));
        start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        reset = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (act !== exp_ctl(-1, 8'h00)) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected %b", act, exp_ctl(-1, 8'h00));
        end
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done !== 1'b0) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses expected 0", pulses);
        end
        reset = 1'b1;
        run_op(8'd100, 8'd7, -1, -1, lat, pulses, got);
        exp = sb.pop_front();
        n_checks++;
        if (lat !== 19) begin
            n_fail++;
            $display("FAIL restart_latency: got %0d expected 19", lat);
        end
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL restart_result: got q=%0d r=%0d expected q=%0d r=%0d",
                     got.q, got.r, exp.q, exp.r);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ta[3];
        logic [7:0] tb_b[3];
        ctl_t       exp_c;
        result_t    exp;
        int         p;
        int         op;
        ta   = '{8'd100, 8'd200, 8'd77};
        tb_b = '{8'd7,   8'd13,  8'd0};
        dividend_in = ta[0];
        divisor_in  = tb_b[0];
        sb.push_back(ref_div(ta[0], tb_b[0]));
        start = 1'b1;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(negedge clk);
            p  = (cyc - 1) % 20;
            op = (cyc - 1) / 20;
            exp_c = exp_ctl(p, ref_div(ta[op], tb_b[op]).q);
            n_checks++;
            if (act !== exp_c) begin
                n_fail++;
                $display("FAIL b2b_ctl op%0d p%0d: got %b expected %b", op, p, act, exp_c);
            end
            if (p == 1 && op < 2) begin
                dividend_in = ta[op+1];
                divisor_in  = tb_b[op+1];
                sb.push_back(ref_div(ta[op+1], tb_b[op+1]));
            end
            if (p == 18 && sb.size() > 0) begin
                exp = sb.pop_front();
                n_checks++;
                if ({quo, rmd} !== exp) begin
                    n_fail++;
                    $display("FAIL b2b_result op%0d: got q=%0d r=%0d expected q=%0d r=%0d",
                             op, quo, rmd, exp.q, exp.r);
                end
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_divide;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
